wb_commit_grf: RTL
==================

WB_COMMIT_GRF -- requirements
Module: wb_commit_grf

Interface
REQ-001 SHALL provide ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset_Wb  input  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge only.
REQ-003 SHALL provide: pc_Wb  input  32  PC of the instruction in WB.
REQ-004 SHALL provide: instr_Wb  input  32  instruction word in WB.
REQ-005 SHALL provide: dmRd_Wb  input  32  raw aligned DM word read in MEM.
REQ-006 SHALL provide: aluAns_Wb  input  32  ALU result; for loads, the byte address.
REQ-007 SHALL provide: grfWa_Wb  input  5  destination register.
REQ-008 SHALL provide: ifWrGrf_Wb  input  1  WB instruction writes GRF.
REQ-009 SHALL provide: grfRa1_D, grfRa2_D  input  5 each  decode-stage read addresses.
REQ-010 SHALL provide: grfRd1_D, grfRd2_D  output  32 each  combinational read data.
REQ-011 SHALL provide: grfWd_Wb  output  32  combinational selected write data, for forwarding.
REQ-012 SHALL provide: commitCnt  output  32  registered count of performed GRF writes.
REQ-013 SHALL provide: lastWa, lastWd, lastPc  output  5/32/32  registered record of the most recent performed write.

Function
REQ-014 Write-data select from instr_Wb[31:26]: 0x23 lw -> dmRd_Wb; 0x20 lb / 0x24 lbu -> byte at aluAns_Wb[1:0], sign- or zero-extended; 0x21 lh / 0x25 lhu -> halfword at aluAns_Wb[1], sign- or zero-extended; 0x03 jal, or opcode 0 with funct 0x09 (jalr) -> pc_Wb+8, mod 2^32; all others -> aluAns_Wb.
REQ-015 Byte lanes little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24. Halfword offset 0 = bits 15:0. lw ignores aluAns_Wb[1:0]. lh/lhu ignore aluAns_Wb[0].
REQ-016 A write is performed at a rising edge iff reset_Wb=1, ifWrGrf_Wb=1 and grfWa_Wb!=0. Register k then holds grfWd_Wb.
REQ-017 Register 0 SHALL always read 0. Writes to 0 are discarded and are not counted.
REQ-018 Reads are combinational from the array with zero latency. A performed write becomes visible in the array the cycle after its edge.
REQ-019 Each performed write SHALL add 1 to commitCnt, which wraps 0xFFFFFFFF -> 0x00000000 with no flag.
REQ-020 Each performed write SHALL load lastWa, lastWd and lastPc from grfWa_Wb, grfWd_Wb and pc_Wb. They hold otherwise.
REQ-021 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-022 On an edge with reset_Wb=0: all 31 registers -> 0, commitCnt -> 0, lastWa/lastWd/lastPc -> 0.
REQ-023 Reset SHALL take priority over a simultaneous write. That write is lost, not deferred.
REQ-024 Deasserting reset mid-stream SHALL resume normal writes from the first edge with reset_Wb=1. Combinational outputs SHALL track their inputs during reset.

Configuration
REQ-025 Macro GRF_WB_BYPASS_EN.
- Defined: grfRdN_D returns grfWd_Wb when ifWrGrf_Wb=1, grfWa_Wb!=0, grfWa_Wb=grfRaN_D and reset_Wb=1 (write-before-read in the same cycle).
- Undefined: grfRdN_D returns array contents only, so the old value is seen until the next cycle.
- All other behaviour is identical in both builds.

Verification
REQ-026 Reset low 2 cycles after random writes -> all reads 0, commitCnt=0, last*=0. A write presented during reset is absent afterwards.
REQ-027 lb, instr op 0x20, dmRd_Wb=0x80FF7F01, aluAns_Wb[1:0]=3, grfWa_Wb=8 -> grfWd_Wb=0xFFFFFF80, $8=0xFFFFFF80 next cycle. Same with lhu and offset 2 -> 0x000080FF.
REQ-028 jal, pc_Wb=0x00003010, grfWa_Wb=31 -> $31=0x00003018, lastPc=0x00003010, commitCnt increments by 1.
REQ-029 ifWrGrf_Wb=1, grfWa_Wb=0, aluAns_Wb=0x1234 -> $0 reads 0, commitCnt unchanged.
REQ-030 Write 0xDEADBEEF to $5 with grfRa1_D=5 in the same cycle -> grfRd1_D=0xDEADBEEF that cycle with GRF_WB_BYPASS_EN, old value without it. Both builds read 0xDEADBEEF the next cycle.
REQ-031 Force commitCnt to 0xFFFFFFFF via 2^32-1 writes (or a backdoor preload), then one more write -> commitCnt=0x00000000.

Source files
------------

// File: rtl/wb_commit_grf_if.sv
// Writeback-side bus of the GRF commit block: the WB instruction, decode read
// ports, forwarded write data and the commit trace.
interface wb_commit_grf_if;
  logic [31:0] pc_Wb;
  logic [31:0] instr_Wb;
  logic [31:0] dmRd_Wb;
  logic [31:0] aluAns_Wb;
  logic [4:0]  grfWa_Wb;
  logic        ifWrGrf_Wb;
  logic [4:0]  grfRa1_D;
  logic [4:0]  grfRa2_D;
  logic [31:0] grfRd1_D;
  logic [31:0] grfRd2_D;
  logic [31:0] grfWd_Wb;
  logic [31:0] commitCnt;
  logic [4:0]  lastWa;
  logic [31:0] lastWd;
  logic [31:0] lastPc;

  modport master (
    output pc_Wb, instr_Wb, dmRd_Wb, aluAns_Wb, grfWa_Wb, ifWrGrf_Wb,
           grfRa1_D, grfRa2_D,
    input  grfRd1_D, grfRd2_D, grfWd_Wb, commitCnt, lastWa, lastWd, lastPc
  );

  modport slave (
    input  pc_Wb, instr_Wb, dmRd_Wb, aluAns_Wb, grfWa_Wb, ifWrGrf_Wb,
           grfRa1_D, grfRa2_D,
    output grfRd1_D, grfRd2_D, grfWd_Wb, commitCnt, lastWa, lastWd, lastPc
  );
endinterface

// File: rtl/wb_commit_grf.sv
// WB-stage write-data select, 31x32 general register file and commit trace.
// Optional macro GRF_WB_BYPASS_EN: same-cycle write-to-read bypass on both ports.
module wb_commit_grf (
  input  logic            clk,
  input  logic            reset_Wb,
  wb_commit_grf_if.slave  wb
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] FN_JALR  = 6'h09;

  logic [31:0] regs [31:1];
  logic [31:0] commit_cnt;
  logic [4:0]  last_wa;
  logic [31:0] last_wd, last_pc;

  logic [5:0]  opcode, funct;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wd;
  logic        we;

  assign opcode = wb.instr_Wb[31:26];
  assign funct  = wb.instr_Wb[5:0];

  // Little-endian lane picks; halfwords ignore address bit 0
  always_comb begin
    byte_sel = wb.dmRd_Wb[7:0];
    case (wb.aluAns_Wb[1:0])
      2'd0: byte_sel = wb.dmRd_Wb[7:0];
      2'd1: byte_sel = wb.dmRd_Wb[15:8];
      2'd2: byte_sel = wb.dmRd_Wb[23:16];
      2'd3: byte_sel = wb.dmRd_Wb[31:24];
      default: byte_sel = wb.dmRd_Wb[7:0];
    endcase
  end

  assign half_sel = wb.aluAns_Wb[1] ? wb.dmRd_Wb[31:16] : wb.dmRd_Wb[15:0];

  always_comb begin
    wd = wb.aluAns_Wb;
    case (opcode)
      OP_LW:    wd = wb.dmRd_Wb;
      OP_LB:    wd = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:   wd = {24'h0, byte_sel};
      OP_LH:    wd = {{16{half_sel[15]}}, half_sel};
      OP_LHU:   wd = {16'h0, half_sel};
      OP_JAL:   wd = wb.pc_Wb + 32'd8;
      OP_RTYPE: if (funct == FN_JALR) wd = wb.pc_Wb + 32'd8;
      default:  wd = wb.aluAns_Wb;
    endcase
  end

  assign we = reset_Wb & wb.ifWrGrf_Wb & (wb.grfWa_Wb != 5'd0);

  function automatic logic [31:0] rd_port(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'h0 : regs[ra];
`ifdef GRF_WB_BYPASS_EN
    if (we && (wb.grfWa_Wb == ra)) v = wd;
`endif
    return v;
  endfunction

  assign wb.grfRd1_D  = rd_port(wb.grfRa1_D);
  assign wb.grfRd2_D  = rd_port(wb.grfRa2_D);
  assign wb.grfWd_Wb  = wd;
  assign wb.commitCnt = commit_cnt;
  assign wb.lastWa    = last_wa;
  assign wb.lastWd    = last_wd;
  assign wb.lastPc    = last_pc;

  // Reset wins over a coincident write; that write is dropped for good
  always_ff @(posedge clk) begin
    if (!reset_Wb) begin
      for (int k = 1; k < 32; k++) regs[k] <= 32'h0;
      commit_cnt <= 32'h0;
      last_wa    <= 5'h0;
      last_wd    <= 32'h0;
      last_pc    <= 32'h0;
    end else if (we) begin
      regs[wb.grfWa_Wb] <= wd;
      commit_cnt        <= commit_cnt + 32'd1;
      last_wa           <= wb.grfWa_Wb;
      last_wd           <= wd;
      last_pc           <= wb.pc_Wb;
    end
  end
endmodule
